// File: rtl/eth_axis_pkg.sv
// Shared AXI-Stream word layout and write-FSM states for the TX frame buffer.
// No logic; latency and backpressure are defined by the modules that import it.
package eth_axis_pkg;

  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int ENTRY_W = 37;

  typedef struct packed {
    logic              tlast;
    logic [STRB_W-1:0] tstrb;
    logic [DATA_W-1:0] tdata;
  } axis_word_t;

  typedef enum logic {
    WRITE = 1'b0,
    DROP  = 1'b1
  } wr_state_t;

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port frame storage, one write and one read port, contents not reset.
// Read data registered: 1-cycle latency, held while rd_en is low; no backpressure.
module axis_fifo_ram
  import eth_axis_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic               Clk_user,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_dat,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_dat
);

  logic [ENTRY_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge Clk_user) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_tx_frame_fifo.sv
// Store-and-forward TX frame buffer; oversize/overflowing frames are dropped whole.
// tlast accepted at N -> Frame_cnt at N+1 -> first word valid at N+2; source is never backpressured.
module axis_tx_frame_fifo
  import eth_axis_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int FCNT_W = 8
) (
  input  logic              Clk_user,
  input  logic              Reset,
  input  logic [31:0]       S_AXIS_tdata,
  input  logic [3:0]        S_AXIS_tstrb,
  input  logic              S_AXIS_tlast,
  input  logic              S_AXIS_tvalid,
  output logic              S_AXIS_tready,
  output logic [31:0]       M_AXIS_tdata,
  output logic [3:0]        M_AXIS_tstrb,
  output logic              M_AXIS_tlast,
  output logic              M_AXIS_tvalid,
  input  logic              M_AXIS_tready,
  output logic              Frame_drop,
  output logic [FCNT_W-1:0] Frame_cnt
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wr_ptr, wr_commit, rd_ptr;
  wr_state_t     state, state_nxt;
  logic          s_rdy_q, drop_q;
  logic          full, wr_acc, ram_wr_en, commit_vld, rewind;

  // Read-side pipeline: RAM output register followed by a 2-entry skid queue.
  axis_word_t    wr_word, ram_q, skid0, skid1, skid0_nxt, skid1_nxt, head;
  logic [ENTRY_W-1:0] ram_rd_dat;
  logic          ram_vld, m_vld, pop, pop_skid, push, rd_issue, dec;
  logic [1:0]    skid_cnt, skid_cnt_nxt, skid_base;

  assign full    = (wr_ptr == {~rd_ptr[ADDR_W], rd_ptr[ADDR_W-1:0]});
  assign wr_acc  = S_AXIS_tvalid && s_rdy_q;
  assign wr_word = '{tlast: S_AXIS_tlast, tstrb: S_AXIS_tstrb, tdata: S_AXIS_tdata};

  always_comb begin
    state_nxt  = state;
    ram_wr_en  = 1'b0;
    commit_vld = 1'b0;
    rewind     = 1'b0;
    case (state)
      WRITE: begin
        if (wr_acc) begin
          if (!full) begin
            ram_wr_en  = 1'b1;
            commit_vld = S_AXIS_tlast;
          end else if (S_AXIS_tlast) begin
            rewind = 1'b1;
          end else begin
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        if (wr_acc && S_AXIS_tlast) begin
          rewind    = 1'b1;
          state_nxt = WRITE;
        end
      end
      default: state_nxt = WRITE;
    endcase
  end

  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      state     <= WRITE;
      s_rdy_q   <= 1'b0;
      drop_q    <= 1'b0;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      state   <= state_nxt;
      s_rdy_q <= 1'b1;
      drop_q  <= rewind;
      if (rewind)         wr_ptr <= wr_commit;
      else if (ram_wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (commit_vld)     wr_commit <= wr_ptr + PW'(1);
    end
  end

  assign ram_q    = axis_word_t'(ram_rd_dat);
  assign m_vld    = (skid_cnt != 2'd0) || ram_vld;
  assign pop      = m_vld && M_AXIS_tready;
  assign pop_skid = pop && (skid_cnt != 2'd0);
  // The RAM word is parked in the skid queue unless it leaves directly this cycle.
  assign push     = ram_vld && !(pop && (skid_cnt == 2'd0));
  assign skid_base    = skid_cnt - {1'b0, pop_skid};
  assign skid_cnt_nxt = skid_base + {1'b0, push};
  assign rd_issue     = (rd_ptr != wr_commit) && (skid_cnt_nxt < 2'd2);
  assign dec          = pop && head.tlast;

  always_comb begin
    head = '0;
    if (skid_cnt != 2'd0) head = skid0;
    else if (ram_vld)     head = ram_q;
  end

  always_comb begin
    skid0_nxt = skid0;
    skid1_nxt = skid1;
    if (pop_skid) skid0_nxt = skid1;
    if (push) begin
      if (skid_base == 2'd0) skid0_nxt = ram_q;
      else                   skid1_nxt = ram_q;
    end
  end

  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      rd_ptr    <= '0;
      ram_vld   <= 1'b0;
      skid_cnt  <= 2'd0;
      skid0     <= '0;
      skid1     <= '0;
      Frame_cnt <= '0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + PW'(1);
      ram_vld  <= rd_issue;
      skid_cnt <= skid_cnt_nxt;
      skid0    <= skid0_nxt;
      skid1    <= skid1_nxt;
      if (commit_vld && !dec) begin
        if (Frame_cnt != '1) Frame_cnt <= Frame_cnt + FCNT_W'(1);
      end else if (dec && !commit_vld) begin
        Frame_cnt <= Frame_cnt - FCNT_W'(1);
      end
    end
  end

  axis_fifo_ram #(.ADDR_W(ADDR_W)) u_ram (
    .Clk_user (Clk_user),
    .wr_en    (ram_wr_en),
    .wr_addr  (wr_ptr[ADDR_W-1:0]),
    .wr_dat   (wr_word),
    .rd_en    (rd_issue),
    .rd_addr  (rd_ptr[ADDR_W-1:0]),
    .rd_dat   (ram_rd_dat)
  );

  assign S_AXIS_tready = s_rdy_q;
  assign M_AXIS_tvalid = m_vld;
  assign M_AXIS_tdata  = head.tdata;
  assign M_AXIS_tstrb  = head.tstrb;
  assign M_AXIS_tlast  = head.tlast;
  assign Frame_drop    = drop_q;

endmodule

// File: tb/tb_axis_tx_frame_fifo.sv
// Bench for the TX frame buffer: a 512-deep and a 16-deep instance share one driver,
// a queue-based scoreboard holds every word the source sent in a frame that must survive.
module tb_axis_tx_frame_fifo;
  import eth_axis_pkg::*;

  logic        Clk_user = 1'b0;
  logic        Reset;
  logic        sel;
  logic [31:0] s_dat;
  logic [3:0]  s_strb;
  logic        s_last, s_vld, rdy, rnd_rdy;

  logic        b_s_rdy, b_m_last, b_m_vld, b_drop;
  logic [31:0] b_m_dat;
  logic [3:0]  b_m_strb;
  logic [7:0]  b_cnt;
  logic        m_s_rdy, sm_m_last, sm_m_vld, sm_drop;
  logic [31:0] sm_m_dat;
  logic [3:0]  sm_m_strb;
  logic [7:0]  sm_cnt;

  logic        s_rdy, m_vld, drop;
  logic [7:0]  cnt;
  axis_word_t  m_word;

  always #5 Clk_user = ~Clk_user;

  axis_tx_frame_fifo u_big (
    .Clk_user(Clk_user), .Reset(Reset),
    .S_AXIS_tdata(s_dat), .S_AXIS_tstrb(s_strb), .S_AXIS_tlast(s_last),
    .S_AXIS_tvalid(s_vld && !sel), .S_AXIS_tready(b_s_rdy),
    .M_AXIS_tdata(b_m_dat), .M_AXIS_tstrb(b_m_strb), .M_AXIS_tlast(b_m_last),
    .M_AXIS_tvalid(b_m_vld), .M_AXIS_tready(rdy && !sel),
    .Frame_drop(b_drop), .Frame_cnt(b_cnt)
  );

  axis_tx_frame_fifo #(.ADDR_W(4)) u_small (
    .Clk_user(Clk_user), .Reset(Reset),
    .S_AXIS_tdata(s_dat), .S_AXIS_tstrb(s_strb), .S_AXIS_tlast(s_last),
    .S_AXIS_tvalid(s_vld && sel), .S_AXIS_tready(m_s_rdy),
    .M_AXIS_tdata(sm_m_dat), .M_AXIS_tstrb(sm_m_strb), .M_AXIS_tlast(sm_m_last),
    .M_AXIS_tvalid(sm_m_vld), .M_AXIS_tready(rdy && sel),
    .Frame_drop(sm_drop), .Frame_cnt(sm_cnt)
  );

  assign s_rdy  = sel ? m_s_rdy  : b_s_rdy;
  assign m_vld  = sel ? sm_m_vld : b_m_vld;
  assign drop   = sel ? sm_drop  : b_drop;
  assign cnt    = sel ? sm_cnt   : b_cnt;
  assign m_word = sel ? {sm_m_last, sm_m_strb, sm_m_dat} : {b_m_last, b_m_strb, b_m_dat};

  int         checks = 0;
  int         errors = 0;
  int         drop_cnt = 0;
  int         maxc = 0;
  axis_word_t exp_q[$];
  axis_word_t prev_w;
  logic       prev_stall = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares every accepted output word against the scoreboard.
  always @(negedge Clk_user) begin
    if (Reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_vld", m_vld, 1);
        chk("stall_word", m_word, prev_w);
      end
      if (m_vld && rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected no word", m_word);
        end else begin
          chk("out_word", m_word, exp_q.pop_front());
        end
      end
      prev_stall <= m_vld && !rdy;
      prev_w     <= m_word;
      if (drop) drop_cnt <= drop_cnt + 1;
      if (int'(cnt) > maxc) maxc <= int'(cnt);
    end
  end

  task automatic step();
    @(posedge Clk_user);
    #1;
    if (rnd_rdy) rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    s_vld = 1'b0;
    repeat (n) step();
  endtask

  // Drives the first nsend words of a len-word frame; keep=1 means it must arrive intact.
  task automatic send_frame(input int len, input int nsend, input bit keep);
    axis_word_t w;
    for (int i = 0; i < nsend; i++) begin
      w.tdata = $urandom;
      w.tstrb = 4'($urandom);
      w.tlast = (i == len - 1);
      s_dat = w.tdata;
      s_strb = w.tstrb;
      s_last = w.tlast;
      s_vld = 1'b1;
      if (keep) exp_q.push_back(w);
      @(negedge Clk_user);
      chk("s_tready", s_rdy, 1);
      step();
    end
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      step();
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_s_tready", s_rdy, 0);
    chk("rst_m_tvalid", m_vld, 0);
    chk("rst_m_word", m_word, 0);
    chk("rst_drop", drop, 0);
    chk("rst_cnt", cnt, 0);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int d0, n, len, t;
    Reset = 1'b1; sel = 1'b0; s_vld = 1'b0; s_dat = '0; s_strb = '0; s_last = 1'b0;
    rdy = 1'b0; rnd_rdy = 1'b0;
    repeat (3) @(posedge Clk_user);
    @(negedge Clk_user);
    chk_reset_vals();
    chk("rst_small_tready", m_s_rdy, 0);
    @(posedge Clk_user);
    #1 Reset = 1'b0;
    step();
    @(negedge Clk_user);
    chk("tready_rise", s_rdy, 1);
    step();

    // Single 16-word frame, output ready: valid two cycles after tlast.
    rdy = 1'b1;
    send_frame(16, 16, 1);
    s_vld = 1'b0;
    @(negedge Clk_user);
    chk("t1_cnt_after_tlast", cnt, 1);
    chk("t1_vld_n1", m_vld, 0);
    step();
    @(negedge Clk_user);
    chk("t1_vld_n2", m_vld, 1);
    wait_drain(40);
    idle(1);
    chk("t1_cnt_end", cnt, 0);

    // Three frames stored while output blocked, then released contiguously.
    rdy = 1'b0;
    send_frame(5, 5, 1);
    send_frame(1, 1, 1);
    send_frame(64, 64, 1);
    idle(3);
    @(negedge Clk_user);
    chk("t2_cnt3", cnt, 3);
    step();
    rdy = 1'b1;
    n = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge Clk_user);
      if (m_vld) n++;
    end
    chk("t2_contiguous", n, 70);
    wait_drain(20);
    idle(1);
    chk("t2_cnt_end", cnt, 0);
    chk("t12_no_drop", drop_cnt, 0);

    // Small instance: oversize frame dropped, following frame intact.
    sel = 1'b1;
    idle(2);
    d0 = drop_cnt;
    send_frame(20, 20, 0);
    idle(3);
    chk("t3_drop_once", drop_cnt - d0, 1);
    chk("t3_cnt", cnt, 0);
    send_frame(4, 4, 1);
    idle(1);
    wait_drain(20);
    chk("t3_drop_total", drop_cnt - d0, 1);

    // Small instance: second frame overflows behind a stored 12-word frame.
    rdy = 1'b0;
    d0 = drop_cnt;
    send_frame(12, 12, 1);
    send_frame(8, 8, 0);
    idle(3);
    chk("t4_drop_once", drop_cnt - d0, 1);
    chk("t4_cnt", cnt, 1);
    rdy = 1'b1;
    wait_drain(40);
    idle(1);
    chk("t4_cnt_end", cnt, 0);

    // Random frames with random output ready; admission keeps the buffer from overflowing.
    d0 = drop_cnt;
    rnd_rdy = 1'b1;
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(1, 16);
      t = 0;
      while (exp_q.size() + len > 16 && t < 500) begin
        idle(1);
        t++;
      end
      chk("t5_space", (exp_q.size() + len <= 16), 1);
      send_frame(len, len, 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    s_vld = 1'b0;
    wait_drain(600);
    rnd_rdy = 1'b0;
    rdy = 1'b1;
    idle(2);
    chk("t5_no_drop", drop_cnt - d0, 0);
    chk("t5_cnt_end", cnt, 0);

    // Reset mid-write and mid-read on the large instance.
    sel = 1'b0;
    idle(2);
    d0 = drop_cnt;
    send_frame(10, 4, 0);
    Reset = 1'b1;
    s_vld = 1'b0;
    @(negedge Clk_user);
    chk_reset_vals();
    step();
    Reset = 1'b0;
    idle(2);
    rdy = 1'b0;
    send_frame(30, 30, 1);
    idle(2);
    rdy = 1'b1;
    repeat (5) step();
    Reset = 1'b1;
    exp_q.delete();
    @(negedge Clk_user);
    chk_reset_vals();
    step();
    Reset = 1'b0;
    step();
    @(negedge Clk_user);
    chk("t6_tready_back", s_rdy, 1);
    step();
    send_frame(7, 7, 1);
    idle(1);
    wait_drain(30);
    idle(1);
    chk("t6_cnt_end", cnt, 0);
    chk("t6_no_drop", drop_cnt - d0, 0);
    chk("fcnt_not_saturated", (maxc < 255), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_tx_frame_fifo.md
# axis_tx_frame_fifo

Store-and-forward frame buffer between the user AXI-Stream source and the MAC TX user interface, in the `Clk_user` domain. A frame is released downstream only after its `tlast` word has been accepted, so the MAC never underruns mid-frame. Frames that cannot fit are discarded whole and reported.

## Interface

Parameters:
- `ADDR_W`, 9: log2 of buffer depth in 32-bit words (default 512 words).
- `FCNT_W`, 8: width of the stored-frame counter.

Ports:
- `Clk_user` in 1: single clock. All logic is rising-edge.
- `Reset` in 1: asynchronous, active-high reset.
- `S_AXIS_tdata` in 32: write-side data.
- `S_AXIS_tstrb` in 4: byte strobes. Stored verbatim.
- `S_AXIS_tlast` in 1: last word of frame.
- `S_AXIS_tvalid` in 1: write-side valid.
- `S_AXIS_tready` out 1: write-side ready.
- `M_AXIS_tdata` out 32: read-side data.
- `M_AXIS_tstrb` out 4: read-side strobes.
- `M_AXIS_tlast` out 1: read-side last.
- `M_AXIS_tvalid` out 1: read-side valid.
- `M_AXIS_tready` in 1: read-side ready.
- `Frame_drop` out 1: one-cycle pulse when a frame has been discarded.
- `Frame_cnt` out FCNT_W: number of complete frames currently stored.

## Operation

- Each storage entry is 37 bits: {tlast, tstrb, tdata}. Depth is 2^ADDR_W.
- Pointers are ADDR_W+1 bits with a wrap bit:
  - Full: pointers are equal except for the MSB.
  - Empty: pointers are fully equal.
- Pointers in use: `wr_ptr` (speculative), `wr_commit` (end of last complete frame), `rd_ptr`.
- A write occurs on `S_AXIS_tvalid && S_AXIS_tready` in state WRITE. `wr_ptr` increments by 1.
  - If `tlast` is set: `wr_commit <= wr_ptr+1` and `Frame_cnt` increments.
- Write FSM has two states, WRITE and DROP:
  - WRITE → DROP when `S_AXIS_tvalid` is high while the buffer is full. That word is not stored.
  - In DROP, `S_AXIS_tready` = 1 and all words are consumed and discarded.
  - DROP → WRITE on an accepted `tlast`. At that transition `wr_ptr <= wr_commit` and `Frame_drop` pulses in the next cycle.
  - If the overflowing word itself carries `tlast`: rewind, pulse, and stay in WRITE.
- `S_AXIS_tready` = 1 in WRITE and in DROP. It is 0 only during reset.
  - Consequence: overflow never backpressures the source; it drops the frame.
- Frames larger than the depth are always dropped. The buffer stays consistent.
- Read side fetches from RAM while `rd_ptr != wr_commit`, i.e. committed data remains. Only committed words are ever read.
- When a word with `tlast` is accepted on M_AXIS (`tvalid && tready`), `Frame_cnt` decrements.
  - A simultaneous commit and read-out leaves `Frame_cnt` unchanged.
- `Frame_cnt` saturates at 2^FCNT_W−1. Designers size FCNT_W so this cannot occur; the bench asserts it never does.

## Timing

- Reset values: `S_AXIS_tready`=0, `M_AXIS_tvalid`=0, `M_AXIS_tdata/tstrb/tlast`=0, `Frame_drop`=0, `Frame_cnt`=0. All pointers are 0 and the FSM is in WRITE.
- `S_AXIS_tready` rises in the first cycle after `Reset` deasserts.
- RAM read latency is 1 cycle. A 2-entry output skid register gives one word per cycle sustained when `M_AXIS_tready` is held high.
- Latency: `tlast` accepted at cycle N → `Frame_cnt` updates at N+1 → first word of that frame has `M_AXIS_tvalid`=1 at N+2.
  - Applies only when the output is idle; otherwise words queue behind earlier frames.
- Back-to-back frames on M_AXIS have no idle cycle between `tlast` and the next first word.
- `M_AXIS_*` stays stable while `tvalid && !tready` (AXIS rule).
- Reset asserted mid-frame clears everything immediately. Partial and stored frames are lost and no `Frame_drop` pulse is produced.

## Structure

- Package `eth_axis_pkg` holds:
  - `localparam DATA_W=32`, `STRB_W=4`, `ENTRY_W=37`.
  - typedef `axis_word_t` = {tlast, tstrb, tdata}.
  - enum `wr_state_t` {WRITE, DROP}.
- Sub-module `axis_fifo_ram`: simple dual-port RAM, 2^ADDR_W × ENTRY_W, registered read, no reset on contents.
- Top level holds the pointers, write FSM, frame counter and output skid stage.

## Test plan

- Single 16-word frame, `M_AXIS_tready`=1 → `tvalid` 2 cycles after `tlast`, 16 identical words out, `Frame_cnt` goes 1 then 0.
- Three frames of 5/1/64 words written back to back, `M_AXIS_tready` held 0 → `Frame_cnt`=3. Then release `tready`: 70 words out contiguously, `tlast` on words 5, 6 and 70.
- ADDR_W=4, 20-word frame → `S_AXIS_tready` stays 1, `Frame_drop` pulses once, `Frame_cnt`=0, nothing emitted. A following 4-word frame passes intact.
- ADDR_W=4, fill with a 12-word frame, then send an 8-word frame → second frame dropped, first delivered unchanged.
- Random `M_AXIS_tready` (50%) with continuous random frames → scoreboard matches data, strobes and tlast. Wrap-around exercised over more than 3× depth.
- `Reset` pulsed mid-write and mid-read → all outputs return to reset values. The next frame is delivered correctly.
